// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue queue: opcode encodings, sequencer
// states, the queued-instruction record and opcode decode helpers.
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_FLW  = 3'd1,
        OP_FSW  = 3'd2,
        OP_FADD = 3'd3,
        OP_FMUL = 3'd4,
        OP_FDIV = 3'd5
    } fpu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } iq_state_e;

    typedef struct packed {
        fpu_op_e     op;
        logic [31:0] rs1;
        logic [31:0] frs1;
        logic [31:0] frs2;
        logic [31:0] imm;
        logic [4:0]  frd;
        logic        wr;
    } iq_entry_t;

    function automatic logic op_legal(input fpu_op_e op);
        return (op == OP_FLW) || (op == OP_FSW) || (op == OP_FADD) ||
               (op == OP_FMUL) || (op == OP_FDIV);
    endfunction

    function automatic logic op_writes(input fpu_op_e op);
        return (op == OP_FLW) || (op == OP_FADD) || (op == OP_FMUL) || (op == OP_FDIV);
    endfunction

    function automatic logic op_reads_frs1(input fpu_op_e op);
        return (op == OP_FADD) || (op == OP_FMUL) || (op == OP_FDIV);
    endfunction

    function automatic logic op_reads_frs2(input fpu_op_e op);
        return (op == OP_FSW) || (op == OP_FADD) || (op == OP_FMUL) || (op == OP_FDIV);
    endfunction

    // Bit order {fdiv, fmul, fadd, fsw, flw}
    function automatic logic [4:0] op_onehot(input fpu_op_e op);
        logic [4:0] oh;
        oh = '0;
        case (op)
            OP_FLW:  oh[0] = 1'b1;
            OP_FSW:  oh[1] = 1'b1;
            OP_FADD: oh[2] = 1'b1;
            OP_FMUL: oh[3] = 1'b1;
            OP_FDIV: oh[4] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fpu_issue_queue_if.sv
// Decode-side enqueue handshake and FPU-side dispatch/completion bundle.
// slave = the issue queue, master = decode stage plus FPU.
interface fpu_issue_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_frs1;
    logic [31:0] in_frs2;
    logic [4:0]  in_frs1_addr;
    logic [4:0]  in_frs2_addr;
    logic [4:0]  in_frd;
    logic [31:0] in_imm;

    logic        fpu_enabled;
    logic        fpu_instr_flw;
    logic        fpu_instr_fsw;
    logic        fpu_instr_fadd;
    logic        fpu_instr_fmul;
    logic        fpu_instr_fdiv;
    logic [31:0] fpu_reg_rs1;
    logic [31:0] fpu_freg_rs1;
    logic [31:0] fpu_freg_rs2;
    logic [31:0] fpu_imm;
    logic [4:0]  fpu_frd_addr;
    logic        fpu_busy;
    logic        fpu_completed;

    modport master (
        output in_valid, in_op, in_rs1, in_frs1, in_frs2, in_frs1_addr,
               in_frs2_addr, in_frd, in_imm, fpu_busy, fpu_completed,
        input  in_ready, fpu_enabled, fpu_instr_flw, fpu_instr_fsw,
               fpu_instr_fadd, fpu_instr_fmul, fpu_instr_fdiv, fpu_reg_rs1,
               fpu_freg_rs1, fpu_freg_rs2, fpu_imm, fpu_frd_addr
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_frs1, in_frs2, in_frs1_addr,
               in_frs2_addr, in_frd, in_imm, fpu_busy, fpu_completed,
        output in_ready, fpu_enabled, fpu_instr_flw, fpu_instr_fsw,
               fpu_instr_fadd, fpu_instr_fmul, fpu_instr_fdiv, fpu_reg_rs1,
               fpu_freg_rs1, fpu_freg_rs2, fpu_imm, fpu_frd_addr
    );
endinterface

// File: rtl/fpu_iq_fifo.sv
// DEPTH-entry synchronous FIFO of queued FP instructions. Head entry is
// presented combinationally on data_o; push/pop are ignored when full/empty.
module fpu_iq_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  iq_entry_t        data_i,
    input  logic             pop_i,
    output iq_entry_t        data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    iq_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// In-order FP issue queue and dispatch sequencer with a destination-register
// scoreboard that blocks RAW/WAW hazards at enqueue.
// Optional macro FPU_TIMEOUT_EN adds a WAIT-state watchdog (TIMEOUT cycles).
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PTR_W   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    fpu_issue_queue_if.slave    bus,
    output logic [31:0]         pend_mask,
    output logic [PTR_W:0]      q_count,
    output logic                timeout_err
);

    iq_state_e   state_q;
    logic [31:0] pend_q, pend_d;
    logic        full, empty, hazard, accept, push, pop, wait_done, tmo_hit;
    fpu_op_e     in_op_e;
    iq_entry_t   in_entry, head;

    logic        fpu_enabled_q, issue_wr_q, inflight_wr_q;
    logic [4:0]  instr_q, frd_q, inflight_frd_q;
    logic [31:0] reg_rs1_q, freg_rs1_q, freg_rs2_q, imm_q;

    assign in_op_e = fpu_op_e'(bus.in_op);

    // Hazard check against the registered mask only
    always_comb begin
        hazard = 1'b0;
        if (op_reads_frs1(in_op_e) && pend_q[bus.in_frs1_addr]) hazard = 1'b1;
        if (op_reads_frs2(in_op_e) && pend_q[bus.in_frs2_addr]) hazard = 1'b1;
        if (op_writes(in_op_e) && pend_q[bus.in_frd])           hazard = 1'b1;
    end

    assign bus.in_ready = rst_n & ~full & ~hazard;
    assign accept       = bus.in_valid & bus.in_ready;
    assign push         = accept & op_legal(in_op_e);
    assign pop          = (state_q == S_IDLE) & ~empty & ~bus.fpu_busy;
    assign wait_done    = (state_q == S_WAIT) & (bus.fpu_completed | tmo_hit);

    assign in_entry = '{op: in_op_e, rs1: bus.in_rs1, frs1: bus.in_frs1,
                        frs2: bus.in_frs2, imm: bus.in_imm, frd: bus.in_frd,
                        wr: op_writes(in_op_e)};

    fpu_iq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (in_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (q_count)
    );

    // Scoreboard next state: retire the in-flight destination, mark the new one
    always_comb begin
        pend_d = pend_q;
        if (wait_done && inflight_wr_q) pend_d[inflight_frd_q] = 1'b0;
        if (push && in_entry.wr)        pend_d[bus.in_frd]     = 1'b1;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    // Dispatch sequencer with registered FPU-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            fpu_enabled_q  <= 1'b0;
            instr_q        <= '0;
            reg_rs1_q      <= '0;
            freg_rs1_q     <= '0;
            freg_rs2_q     <= '0;
            imm_q          <= '0;
            frd_q          <= '0;
            issue_wr_q     <= 1'b0;
            inflight_frd_q <= '0;
            inflight_wr_q  <= 1'b0;
        end else begin
            fpu_enabled_q <= 1'b0;
            instr_q       <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        fpu_enabled_q <= 1'b1;
                        instr_q       <= op_onehot(head.op);
                        reg_rs1_q     <= head.rs1;
                        freg_rs1_q    <= head.frs1;
                        freg_rs2_q    <= head.frs2;
                        imm_q         <= head.imm;
                        frd_q         <= head.frd;
                        issue_wr_q    <= head.wr;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    inflight_frd_q <= frd_q;
                    inflight_wr_q  <= issue_wr_q;
                    state_q        <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_done) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FPU_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TO_W-1:0] tmo_cnt_q;
    logic            timeout_err_q;

    // Fires on the TIMEOUT-th WAIT cycle that sees no completion
    assign tmo_hit = (state_q == S_WAIT) & ~bus.fpu_completed &
                     (tmo_cnt_q == TO_W'(TIMEOUT - 1));

    // Watchdog counter, cleared whenever the sequencer is outside WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= tmo_hit;
            if (state_q == S_WAIT && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                               tmo_cnt_q <= '0;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT != 0);
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign pend_mask          = pend_q;
    assign bus.fpu_enabled    = fpu_enabled_q;
    assign bus.fpu_instr_flw  = instr_q[0];
    assign bus.fpu_instr_fsw  = instr_q[1];
    assign bus.fpu_instr_fadd = instr_q[2];
    assign bus.fpu_instr_fmul = instr_q[3];
    assign bus.fpu_instr_fdiv = instr_q[4];
    assign bus.fpu_reg_rs1    = reg_rs1_q;
    assign bus.fpu_freg_rs1   = freg_rs1_q;
    assign bus.fpu_freg_rs2   = freg_rs2_q;
    assign bus.fpu_imm        = imm_q;
    assign bus.fpu_frd_addr   = frd_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue: single-instruction vector table plus
// hand-written RAW, back-to-back, fill and mid-operation reset sequences.
module tb_fpu_issue_queue;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fpu_issue_queue_if bus();
    logic [31:0] pend_mask;
    logic [2:0]  q_count;
    logic        timeout_err;

    fpu_issue_queue #(.DEPTH(4), .PTR_W(2), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .pend_mask   (pend_mask),
        .q_count     (q_count),
        .timeout_err (timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs1, frs1, frs2, imm;
        logic [4:0]  a1, a2, frd;
        logic [4:0]  exp_instr;   // {fdiv,fmul,fadd,fsw,flw}
        logic [31:0] exp_pend;
        logic        legal;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] frs1,
                         input logic [31:0] frs2, input logic [31:0] imm, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] frd);
        bus.in_valid     = 1'b1;
        bus.in_op        = op;
        bus.in_rs1       = rs1;
        bus.in_frs1      = frs1;
        bus.in_frs2      = frs2;
        bus.in_imm       = imm;
        bus.in_frs1_addr = a1;
        bus.in_frs2_addr = a2;
        bus.in_frd       = frd;
    endtask

    function automatic logic [4:0] instr_bits();
        return {bus.fpu_instr_fdiv, bus.fpu_instr_fmul, bus.fpu_instr_fadd,
                bus.fpu_instr_fsw, bus.fpu_instr_flw};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{3'd3, 32'h0, 32'h3F800000, 32'h40000000, 32'h0, 5'd1, 5'd2, 5'd3, 5'b00100, 32'h0000_0008, 1'b1};
        vecs[1] = '{3'd1, 32'h1000, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd5, 5'b00001, 32'h0000_0020, 1'b1};
        vecs[2] = '{3'd2, 32'h2000, 32'h0, 32'hDEADBEEF, 32'h8, 5'd0, 5'd4, 5'd9, 5'b00010, 32'h0000_0000, 1'b1};
        vecs[3] = '{3'd4, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h0, 5'd10, 5'd11, 5'd31, 5'b01000, 32'h8000_0000, 1'b1};
        vecs[4] = '{3'd5, 32'h0, 32'h41200000, 32'h40A00000, 32'h0, 5'd12, 5'd13, 5'd0, 5'b10000, 32'h0000_0001, 1'b1};
        vecs[5] = '{3'd0, 32'h5, 32'h6, 32'h7, 32'h8, 5'd1, 5'd2, 5'd3, 5'b00000, 32'h0000_0000, 1'b0};
        vecs[6] = '{3'd7, 32'h5, 32'h6, 32'h7, 32'h8, 5'd1, 5'd2, 5'd3, 5'b00000, 32'h0000_0000, 1'b0};

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_frs1 = '0;
        bus.in_frs2 = '0; bus.in_imm = '0; bus.in_frs1_addr = '0; bus.in_frs2_addr = '0;
        bus.in_frd = '0; bus.fpu_busy = 1'b0; bus.fpu_completed = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #10;
        chk("rst_q_count", q_count, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_enabled", bus.fpu_enabled, 0);
        chk("rst_instr", instr_bits(), 0);
        chk("rst_reg_rs1", bus.fpu_reg_rs1, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_timeout", timeout_err, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("idle_in_ready", bus.in_ready, 1);

        // Single-instruction vectors into an empty idle queue
        for (int i = 0; i < 7; i++) begin
            offer(vecs[i].op, vecs[i].rs1, vecs[i].frs1, vecs[i].frs2, vecs[i].imm,
                  vecs[i].a1, vecs[i].a2, vecs[i].frd);
            #1 chk("v_ready", bus.in_ready, 1);
            step();
            bus.in_valid = 1'b0;
            chk("v_pend_set", pend_mask, vecs[i].exp_pend);
            chk("v_q_count", q_count, {31'd0, vecs[i].legal});
            chk("v_no_early_en", bus.fpu_enabled, 0);
            step();
            chk("v_enabled", bus.fpu_enabled, {31'd0, vecs[i].legal});
            chk("v_instr", instr_bits(), vecs[i].exp_instr);
            if (vecs[i].legal) begin
                chk("v_reg_rs1", bus.fpu_reg_rs1, vecs[i].rs1);
                chk("v_freg_rs1", bus.fpu_freg_rs1, vecs[i].frs1);
                chk("v_freg_rs2", bus.fpu_freg_rs2, vecs[i].frs2);
                chk("v_imm", bus.fpu_imm, vecs[i].imm);
                chk("v_frd", bus.fpu_frd_addr, vecs[i].frd);
            end
            step();
            chk("v_en_pulse", bus.fpu_enabled, 0);
            chk("v_instr_clr", instr_bits(), 0);
            bus.fpu_completed = 1'b1;
            step();
            bus.fpu_completed = 1'b0;
            chk("v_pend_clr", pend_mask, 0);
            chk("v_q_empty", q_count, 0);
        end

        // RAW: FADD reading f5 while FLW f5 is outstanding
        offer(3'd1, 32'h100, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
        step();
        chk("raw_pend", pend_mask, 32'h20);
        offer(3'd3, 32'h0, 32'h11111111, 32'h22222222, 32'h0, 5'd5, 5'd6, 5'd7);
        #1 chk("raw_blocked0", bus.in_ready, 0);
        step();
        chk("raw_flw_en", bus.fpu_enabled, 1);
        chk("raw_flw_instr", instr_bits(), 5'b00001);
        chk("raw_blocked1", bus.in_ready, 0);
        step();
        chk("raw_blocked2", bus.in_ready, 0);
        chk("raw_q_count", q_count, 0);
        step();
        bus.fpu_completed = 1'b1;
        #1 chk("raw_preclear", bus.in_ready, 0);
        step();
        bus.fpu_completed = 1'b0;
        chk("raw_pend_clr", pend_mask, 0);
        bus.in_frs1 = 32'h40400000;
        #1 chk("raw_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("raw_pend_fadd", pend_mask, 32'h80);
        step();
        chk("raw_fadd_en", bus.fpu_enabled, 1);
        chk("raw_fadd_instr", instr_bits(), 5'b00100);
        chk("raw_fadd_frs1", bus.fpu_freg_rs1, 32'h40400000);
        chk("raw_fadd_frs2", bus.fpu_freg_rs2, 32'h22222222);
        step();
        bus.fpu_completed = 1'b1;
        step();
        bus.fpu_completed = 1'b0;
        chk("raw_done", pend_mask, 0);

        // Back-to-back FLW f1, FLW f2
        offer(3'd1, 32'hA, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1);
        step();
        chk("b2b_pend0", pend_mask, 32'h2);
        offer(3'd1, 32'hB, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2);
        #1 chk("b2b_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("b2b_pend1", pend_mask, 32'h6);
        chk("b2b_en1", bus.fpu_enabled, 1);
        chk("b2b_frd1", bus.fpu_frd_addr, 1);
        chk("b2b_qc", q_count, 1);
        step();
        chk("b2b_en_off", bus.fpu_enabled, 0);
        step();
        chk("b2b_wait_hold", bus.fpu_enabled, 0);
        bus.fpu_completed = 1'b1;
        step();
        bus.fpu_completed = 1'b0;
        chk("b2b_pend2", pend_mask, 32'h4);
        chk("b2b_no_early", bus.fpu_enabled, 0);
        step();
        chk("b2b_en2", bus.fpu_enabled, 1);
        chk("b2b_frd2", bus.fpu_frd_addr, 2);
        chk("b2b_rs1_2", bus.fpu_reg_rs1, 32'hB);
        step();
        bus.fpu_completed = 1'b1;
        step();
        bus.fpu_completed = 1'b0;
        chk("b2b_pend3", pend_mask, 0);

        // Fill with FPU busy, fifth accepted only after first pop, then reset in WAIT
        bus.fpu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(3'd2, 32'h3000 + i, 32'h0, i, 32'h0, 5'd0, 5'(i + 8), 5'd0);
            step();
        end
        offer(3'd2, 32'h3004, 32'h0, 32'h4, 32'h0, 5'd0, 5'd12, 5'd0);
        #1 chk("fill_count", q_count, 4);
        chk("fill_not_ready", bus.in_ready, 0);
        step();
        chk("fill_hold", q_count, 4);
        chk("fill_no_disp", bus.fpu_enabled, 0);
        bus.fpu_busy = 1'b0;
        step();
        bus.fpu_busy = 1'b1;
        chk("fill_pop_count", q_count, 3);
        chk("fill_pop_en", bus.fpu_enabled, 1);
        chk("fill_pop_rs1", bus.fpu_reg_rs1, 32'h3000);
        chk("fill_ready_after", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("fill_fifth", q_count, 4);
        step();
        chk("fill_wait_count", q_count, 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", q_count, 0);
        chk("mid_rst_pend", pend_mask, 0);
        chk("mid_rst_rs1", bus.fpu_reg_rs1, 0);
        chk("mid_rst_frs2", bus.fpu_freg_rs2, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        bus.fpu_busy = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_en", bus.fpu_enabled, 0);
            chk("post_rst_count", q_count, 0);
        end
        chk("post_rst_pend", pend_mask, 0);
        chk("no_timeout", timeout_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
